// File: rtl/rr_grant_arbiter.sv
// Registered round-robin grant arbiter for the arbitrated FIFO path.
// The grant is one-hot or zero and drives the downstream mux select. It is held
// until a transfer completes (o_valid & o_ready) or the granted channel withdraws.
// Optional feature macro: ARB_BURST_EN. When defined, a grant is kept for up to
// BURST_LEN consecutive transfers while its channel keeps requesting.
module rr_grant_arbiter #(
  parameter int CHANNELS  = 2,
  parameter int IDX_W     = $clog2(CHANNELS),
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                o_ready,
  output logic [CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                o_valid,
  output logic [CHANNELS-1:0] pop
);

  typedef enum logic {IDLE, GRANTED} state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;

  logic [IDX_W:0]      win_ptr;   // {found, index}, search starts after ptr
  logic [IDX_W:0]      win_last;  // {found, index}, search starts after current grant
  logic [IDX_W:0]      win;
  logic                xfer;
  logic                keep;
  logic                do_load;

`ifdef ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
  // Without bursting a grant always ends after a single transfer.
  localparam int BURST_LIM = (BURST_LEN >= 1) ? 1 : 1;
`endif

  // First asserted request searching p+1, p+2, ... modulo CHANNELS; p itself last.
  function automatic logic [IDX_W:0] pick(input logic [CHANNELS-1:0] r,
                                          input logic [IDX_W-1:0]    p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] c;
    res = '0;
    // Walk from lowest to highest priority so the highest-priority hit wins.
    for (int i = CHANNELS; i >= 1; i--) begin
      c = IDX_W'((int'(p) + i) % CHANNELS);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  // Next-state logic: arbitration, hold, withdraw, burst continuation.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    win_ptr  = pick(req, ptr_q);
    win_last = pick(req, idx_q);
    win      = win_ptr;
    do_load  = 1'b0;
    xfer     = o_valid & o_ready;
`ifdef ARB_BURST_EN
    cnt_d    = cnt_q;
    keep     = req[idx_q] && ((int'(cnt_q) + 1) < BURST_LEN);
`else
    keep     = req[idx_q] && (BURST_LIM > 1);
`endif

    case (state_q)
      IDLE: begin
        do_load = 1'b1;
      end
      GRANTED: begin
        if (xfer) begin
          if (keep) begin
`ifdef ARB_BURST_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
          end else begin
            // Completed channel becomes lowest priority for the re-arbitration.
            ptr_d   = idx_q;
            win     = win_last;
            do_load = 1'b1;
          end
        end else if (!req[idx_q]) begin
          // Withdraw: pointer stays, remaining requesters compete.
          do_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase

    if (do_load) begin
`ifdef ARB_BURST_EN
      cnt_d = '0;
`endif
      if (win[IDX_W]) begin
        state_d = GRANTED;
        grant_d = {{(CHANNELS-1){1'b0}}, 1'b1} << win[IDX_W-1:0];
        idx_d   = win[IDX_W-1:0];
      end else begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    end
  end

  // State registers with synchronous reset; channel 0 has first priority after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(CHANNELS - 1);
`ifdef ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign o_valid   = |grant_q;
  assign pop       = grant_q & {CHANNELS{o_ready}};

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter (CHANNELS=4): a round-robin
// reference model compared every cycle, plus directed literal expectations.
module tb_rr_grant_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          o_ready = 1'b0;
  logic [N-1:0]  grant, pop;
  logic [IW-1:0] grant_idx;
  logic          o_valid;
  logic [N-1:0]  pop_seen;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.CHANNELS(N), .BURST_LEN(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .o_ready(o_ready),
    .grant(grant), .grant_idx(grant_idx), .o_valid(o_valid), .pop(pop)
  );

`ifdef ARB_BURST_EN
  logic [N-1:0]  grant_b, pop_b, pop_seen_b;
  logic [IW-1:0] idx_b;
  logic          valid_b;
  rr_grant_arbiter #(.CHANNELS(N), .BURST_LEN(3)) u_burst (
    .clk(clk), .rst(rst), .req(req), .o_ready(o_ready),
    .grant(grant_b), .grant_idx(idx_b), .o_valid(valid_b), .pop(pop_b)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: granted channel number (-1 when idle) and last-served channel.
  int mg = -1;
  int mptr = N - 1;
  bit started = 1'b0;

  function automatic int first_req(input logic [N-1:0] r, input int last);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mg      <= -1;
      mptr    <= N - 1;
      started <= 1'b1;
    end else if (mg < 0) begin
      mg <= first_req(req, mptr);
    end else if (o_ready) begin
      mptr <= mg;
      mg   <= first_req(req, mg);
    end else if (!req[mg]) begin
      mg <= first_req(req, mptr);
    end
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0] eg;
    if (started) begin
      eg = (mg < 0) ? '0 : (N'(1) << mg);
      chk("m_grant", 32'(grant), 32'(eg));
      chk("m_idx",   32'(grant_idx), (mg < 0) ? 32'd0 : 32'(mg));
      chk("m_valid", 32'(o_valid), 32'(mg >= 0));
      chk("m_pop",   32'(pop), 32'(eg & {N{o_ready}}));
    end
  end

  // Apply inputs for one cycle; capture that cycle's pop; return just after the edge.
  task automatic tick(input logic [N-1:0] r, input logic o);
    req     = r;
    o_ready = o;
    #1;
    pop_seen = pop;
`ifdef ARB_BURST_EN
    pop_seen_b = pop_b;
`endif
    @(posedge clk);
    #2;
  endtask

  initial begin
    @(posedge clk);
    #2;
    // reset and first grant
    rst = 1'b1;
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_idx",   32'(grant_idx), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_pop",   32'(pop), 32'h0);
    rst = 1'b0;
    tick(4'b1111, 1'b1);
    chk("t1_first_grant", 32'(grant), 32'b0001);
    chk("t1_first_pop",   32'(pop_seen), 32'b0000);
    tick(4'b1111, 1'b1);
    chk("t1_pop0", 32'(pop_seen), 32'b0001);
    chk("t1_g1",   32'(grant), 32'b0010);
    tick(4'b1111, 1'b1);
    chk("t1_pop1", 32'(pop_seen), 32'b0010);
    chk("t1_g2",   32'(grant), 32'b0100);
    tick(4'b1111, 1'b1);
    chk("t1_pop2", 32'(pop_seen), 32'b0100);
    chk("t1_g3",   32'(grant), 32'b1000);
    tick(4'b1111, 1'b1);
    chk("t1_pop3", 32'(pop_seen), 32'b1000);
    chk("t1_g0",   32'(grant), 32'b0001);

    // backpressure: channel 0 withdraws, channel 2 takes over and is held
    tick(4'b0100, 1'b0);
    chk("bp_grant", 32'(grant), 32'b0100);
    chk("bp_idx",   32'(grant_idx), 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick(4'b0100, 1'b0);
      chk("bp_hold_grant", 32'(grant), 32'b0100);
      chk("bp_hold_idx",   32'(grant_idx), 32'd2);
      chk("bp_hold_pop",   32'(pop_seen), 32'b0000);
    end
    tick(4'b0000, 1'b1);
    chk("bp_pop",  32'(pop_seen), 32'b0100);
    chk("bp_idle", 32'(grant), 32'b0000);
    tick(4'b0000, 1'b1);
    chk("bp_idle_pop", 32'(pop_seen), 32'b0000);

    // withdraw: grant on 1, req[1] drops while req[3] is up
    tick(4'b0010, 1'b0);
    chk("wd_g1", 32'(grant), 32'b0010);
    tick(4'b1010, 1'b0);
    chk("wd_hold", 32'(grant), 32'b0010);
    tick(4'b1000, 1'b0);
    chk("wd_g3",  32'(grant), 32'b1000);
    chk("wd_idx", 32'(grant_idx), 32'd3);
    chk("wd_pop", 32'(pop_seen), 32'b0000);
    tick(4'b1000, 1'b1);
    chk("wd_pop3",  32'(pop_seen), 32'b1000);
    chk("wd_regnt", 32'(grant), 32'b1000);
    tick(4'b0000, 1'b1);
    chk("wd_pop3b", 32'(pop_seen), 32'b1000);
    chk("wd_idle",  32'(grant), 32'b0000);

    // wrap-around: last transfer on 3, channels 0 and 3 request
    tick(4'b1001, 1'b0);
    chk("wr_g0", 32'(grant), 32'b0001);
    tick(4'b1001, 1'b1);
    chk("wr_pop0", 32'(pop_seen), 32'b0001);
    chk("wr_g3",   32'(grant), 32'b1000);
    tick(4'b1001, 1'b1);
    chk("wr_pop3", 32'(pop_seen), 32'b1000);
    chk("wr_g0b",  32'(grant), 32'b0001);

    // reset mid-grant
    tick(4'b0100, 1'b0);
    chk("rm_g2",    32'(grant), 32'b0100);
    chk("rm_valid", 32'(o_valid), 32'h1);
    rst = 1'b1;
    tick(4'b0100, 1'b0);
    chk("rm_grant", 32'(grant), 32'h0);
    chk("rm_valid0", 32'(o_valid), 32'h0);
    chk("rm_pop",   32'(pop_seen), 32'h0);
    rst = 1'b0;
    tick(4'b1111, 1'b1);
    chk("rm_g0", 32'(grant), 32'b0001);
    tick(4'b1111, 1'b1);
    chk("rm_pop0", 32'(pop_seen), 32'b0001);
    chk("rm_g1",   32'(grant), 32'b0010);
    tick(4'b0000, 1'b0);
    chk("rm_idle", 32'(grant), 32'b0000);

`ifdef ARB_BURST_EN
    // burst of 3 per grant on the second instance
    begin
      logic [N-1:0] exp_pops [7];
      exp_pops = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
      rst = 1'b1;
      tick(4'b0000, 1'b0);
      rst = 1'b0;
      tick(4'b0011, 1'b1);
      chk("bu_g0", 32'(grant_b), 32'b0001);
      for (int i = 0; i < 7; i++) begin
        tick(4'b0011, 1'b1);
        chk("bu_pop", 32'(pop_seen_b), 32'(exp_pops[i]));
      end
      chk("bu_g0_again", 32'(grant_b), 32'b0001);
      tick(4'b0010, 1'b1);
      chk("bu_drop_pop", 32'(pop_seen_b), 32'b0001);
      chk("bu_drop_g1",  32'(grant_b), 32'b0010);
      tick(4'b0000, 1'b0);
    end
`endif

    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Registered round-robin arbiter that sits directly upstream of the one-hot data mux in the arbitrated FIFO path.
- Takes per-channel requests from the input FIFOs (non-empty flags) and drives a one-hot grant. The grant is the mux select.
- Exchanges a valid/ready handshake with the downstream consumer and returns a per-channel pop strobe to the winning FIFO.
- Guarantees the grant is one-hot or all-zero and stays stable until a transfer completes.

Parameters:
- CHANNELS, 2, number of requesting channels; must be >= 2.
- IDX_W, $clog2(CHANNELS), width of the binary grant index; derived, not overridden.
- BURST_LEN, 4, maximum consecutive transfers per grant; used only when ARB_BURST_EN is defined; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  CHANNELS  per-channel request (FIFO not empty).
- o_ready  input  1  downstream accepts the muxed word this cycle.
- grant  output  CHANNELS  registered one-hot grant; drives the mux select; all-zero when idle.
- grant_idx  output  IDX_W  binary index of the granted channel; 0 when idle.
- o_valid  output  1  muxed data is valid; equals OR-reduction of grant.
- pop  output  CHANNELS  pop strobe, grant & {CHANNELS{o_ready}}; combinational from registered grant and o_ready.

Behaviour:
- Reset (rst=1 at clk edge):
  - grant=0, grant_idx=0, o_valid=0, pop=0.
  - ptr=CHANNELS-1, so channel 0 has highest priority first.
  - burst count=0; state=IDLE.
  - Reset mid-grant drops the grant the next cycle with no pop.
- State register: IDLE or GRANTED. ptr holds the index of the last channel that completed a transfer.
- Arbitration order: search channels ptr+1, ptr+2, … modulo CHANNELS; the first asserted req wins. The channel at ptr is searched last.
- IDLE:
  - o_valid=0.
  - If |req, load grant with the winner and go to GRANTED. Latency is 1 cycle from req to grant; there is no combinational req->grant path.
  - Otherwise stay in IDLE.
- GRANTED, transfer (o_valid & o_ready):
  - pop[g]=1 for exactly one cycle; ptr<=g.
  - Re-arbitrate on the current req, with g now lowest priority.
  - If any req, the new grant loads on the same edge: back-to-back transfers with no bubble. Otherwise go to IDLE.
- GRANTED, no transfer, req[g] still 1: hold grant and grant_idx unchanged; ptr unchanged.
- GRANTED, no transfer, req[g] dropped:
  - Withdraw grant on the next edge; ptr unchanged; no pop.
  - Re-arbitrate among the remaining requests, or go to IDLE if none remain.
- Invariants:
  - grant is always zero or one-hot.
  - grant changes only at a transfer edge, a withdraw, or reset.
  - pop is nonzero only when o_valid & o_ready.
- Fairness: with all req held high and o_ready=1, grants rotate 0,1,…,CHANNELS-1,0 with one transfer each.
- Wrap-around: when ptr=CHANNELS-1, the search starts at 0. When g=CHANNELS-1 and only channel 0 requests, channel 0 is granted.
- Simultaneous events: req changes in the same cycle as a transfer are seen by that cycle's re-arbitration.

Optional Feature:
- Macro: ARB_BURST_EN.
- Defined:
  - A burst counter (width $clog2(BURST_LEN+1)) counts transfers under the current grant.
  - On a transfer, if req[g] is still 1 and count+1 < BURST_LEN, keep grant, increment count, and leave ptr unchanged.
  - Otherwise rotate as normal: ptr<=g, count<=0.
  - count resets to 0 on every new grant, withdraw, and reset.
  - With BURST_LEN=1 the behaviour is identical to the undefined case.
- Undefined: no counter; every transfer rotates; BURST_LEN is ignored.

Test Plan:
- Reset and first grant: CHANNELS=4; assert rst for 2 cycles, then req=4'b1111, o_ready=1.
  - Expected: grant 0001 appears one cycle after req, then 0010, 0100, 1000, 0001, with one pop per cycle and no idle cycles.
- Backpressure: req=4'b0100, o_ready=0 for 5 cycles, then 1 for 1 cycle.
  - Expected: grant=0100 and grant_idx=2 stable for 5 cycles, pop=0; then pop=0100 for exactly one cycle; then IDLE.
- Withdraw: grant=0010 with o_ready=0; drop req[1] while req[3]=1.
  - Expected: next cycle grant=1000, ptr unchanged, no pop on channel 1.
- Wrap-around: ptr=3 (last transfer on channel 3); req=4'b1001.
  - Expected: channel 0 granted, then channel 3 after channel 0 transfers.
- Reset mid-operation: grant=0100, o_valid=1; assert rst for 1 cycle.
  - Expected: grant=0, o_valid=0, pop=0 after the edge; next grant follows the channel-0-first order.
- ARB_BURST_EN, BURST_LEN=3: req=4'b0011 held, o_ready=1.
  - Expected: channel 0 gets 3 consecutive pops, then channel 1 gets 3, repeating.
  - Dropping req[0] after 1 pop hands the grant to channel 1 immediately.
